param_scan_decoder: RTL and testbench

//   Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with active-high enable.

---
 rtl/decoder_pkg.sv | 21 ++
 rtl/onehot_dec.sv | 28 ++
 rtl/param_scan_decoder.sv | 127 ++++++++++++
 tb/tb_param_scan_decoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the one-hot decoder family: mode encodings and the
// one-hot helper used by both the legacy and the scanning decoder.
package decoder_pkg;

   localparam logic [1:0] MODE_DIRECT    = 2'b00;
   localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
   localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
   localparam logic [1:0] MODE_HOLD      = 2'b11;

   // Widest select the helper supports; narrower decoders slice the low bits.
   localparam int unsigned MAX_SEL_W = 8;
   localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] s);
      logic [MAX_OUT_W-1:0] r;
      r    = '0;
      r[s] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with active-high enable.
module onehot_dec
   import decoder_pkg::*;
#(
   parameter  int unsigned SEL_W = 3,
   localparam int unsigned OUT_W = 1 << SEL_W
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [OUT_W-1:0] y
);

   logic [MAX_OUT_W-1:0] full;

   always_comb begin
      full = onehot(MAX_SEL_W'(sel));
   end

   assign y = en ? full[OUT_W-1:0] : '0;

   generate
      if (OUT_W < MAX_OUT_W) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^full[MAX_OUT_W-1:OUT_W];
      end
   endgenerate

endmodule

// File: rtl/param_scan_decoder.sv
// Registered one-hot decoder with direct select, up/down scan at a programmable
// rate, and hold. y always equals onehot(idx) while valid is set.
module param_scan_decoder
   import decoder_pkg::*;
#(
   parameter  int unsigned SEL_W      = 3,
   parameter  int unsigned PRESCALE_W = 4,
   localparam int unsigned OUT_W      = 1 << SEL_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [PRESCALE_W-1:0] scan_div,
   input  logic [SEL_W-1:0]      scan_last,
   output logic [OUT_W-1:0]      y,
   output logic [SEL_W-1:0]      idx,
   output logic                  valid,
   output logic                  wrap
);

   logic [SEL_W-1:0]      idx_q, idx_d;
   logic [OUT_W-1:0]      y_q, y_d;
   logic [OUT_W-1:0]      y_next;
   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic [1:0]            prev_mode_q, prev_mode_d;
   logic                  valid_q, valid_d;
   logic                  wrap_q, wrap_d;
   logic                  mode_change;
   logic                  tick;

   assign mode_change = (mode != prev_mode_q);
   assign tick        = (cnt_q == scan_div);

   always_comb begin
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      wrap_d      = 1'b0;
      prev_mode_d = prev_mode_q;
      if (en) begin
         prev_mode_d = mode;
         case (mode)
            MODE_DIRECT: begin
               idx_d   = sel;
               valid_d = 1'b1;
               cnt_d   = '0;
            end
            MODE_SCAN_UP: begin
               valid_d = 1'b1;
               // A fresh mode restarts the prescaler so the first step is a full period away.
               if (mode_change) begin
                  cnt_d = '0;
               end else if (tick) begin
                  cnt_d = '0;
                  if (idx_q >= scan_last) begin
                     idx_d  = '0;
                     wrap_d = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            MODE_SCAN_DOWN: begin
               valid_d = 1'b1;
               if (mode_change) begin
                  cnt_d = '0;
               end else if (tick) begin
                  cnt_d = '0;
                  if (idx_q == '0) begin
                     idx_d  = scan_last;
                     wrap_d = 1'b1;
                  end else if (idx_q > scan_last) begin
                     idx_d = scan_last;
                  end else begin
                     idx_d = idx_q - 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               // HOLD freezes index, prescaler and valid.
            end
         endcase
      end else begin
         valid_d = 1'b0;
      end
   end

   onehot_dec #(
      .SEL_W (SEL_W)
   ) u_onehot_dec (
      .sel (idx_d),
      .en  (en),
      .y   (y_next)
   );

   assign y_d = (en && (mode == MODE_HOLD)) ? y_q : y_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q       <= '0;
         y_q         <= '0;
         cnt_q       <= '0;
         prev_mode_q <= MODE_DIRECT;
         valid_q     <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         y_q         <= y_d;
         cnt_q       <= cnt_d;
         prev_mode_q <= prev_mode_d;
         valid_q     <= valid_d;
         wrap_q      <= wrap_d;
      end
   end

   assign y     = y_q;
   assign idx   = idx_q;
   assign valid = valid_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_param_scan_decoder.sv
// Directed bench for param_scan_decoder; expected outputs are queued as each
// step is driven and compared after the following rising edge.
module tb_param_scan_decoder;
   import decoder_pkg::*;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [2:0] sel;
   logic [3:0] scan_div;
   logic [2:0] scan_last;
   logic [7:0] y;
   logic [2:0] idx;
   logic       valid;
   logic       wrap;

   typedef struct {
      logic [7:0] y;
      logic [2:0] idx;
      logic       valid;
      logic       wrap;
   } exp_t;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;

   param_scan_decoder #(
      .SEL_W      (3),
      .PRESCALE_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .sel       (sel),
      .scan_div  (scan_div),
      .scan_last (scan_last),
      .y         (y),
      .idx       (idx),
      .valid     (valid),
      .wrap      (wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Queue the expectation, let one edge pass, then compare against the popped entry.
   task automatic cycle(input string tag, input logic [2:0] e_idx, input logic e_valid,
                        input logic e_wrap);
      exp_t e;
      exp_t got;
      logic [7:0] one;
      one     = 8'h01;
      e.idx   = e_idx;
      e.valid = e_valid;
      e.wrap  = e_wrap;
      e.y     = e_valid ? (one << e_idx) : 8'h00;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk({tag, ".y"}, y, got.y);
      chk({tag, ".idx"}, {5'b0, idx}, {5'b0, got.idx});
      chk({tag, ".valid"}, {7'b0, valid}, {7'b0, got.valid});
      chk({tag, ".wrap"}, {7'b0, wrap}, {7'b0, got.wrap});
   endtask

   task automatic drive(input logic d_en, input logic [1:0] d_mode, input logic [2:0] d_sel);
      en   = d_en;
      mode = d_mode;
      sel  = d_sel;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      scan_div    = 4'd0;
      scan_last   = 3'd7;
      drive(1'b0, MODE_DIRECT, 3'd0);
      @(posedge clk);
      #1;
      cycle("reset", 3'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // Direct decode sweep.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, MODE_DIRECT, 3'(i));
         cycle("direct", 3'(i), 1'b1, 1'b0);
      end

      // Disabled in every mode: outputs cleared, index held at 7.
      for (int m = 0; m < 4; m++) begin
         for (int s = 0; s < 8; s++) begin
            drive(1'b0, 2'(m), 3'(s));
            cycle("disabled", 3'd7, 1'b0, 1'b0);
         end
      end

      // Up scan every cycle to scan_last=5.
      drive(1'b1, MODE_DIRECT, 3'd0);
      cycle("up_seed", 3'd0, 1'b1, 1'b0);
      scan_div  = 4'd0;
      scan_last = 3'd5;
      drive(1'b1, MODE_SCAN_UP, 3'd0);
      cycle("up_modechg", 3'd0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) cycle("up_step", 3'(i), 1'b1, 1'b0);
      cycle("up_wrap", 3'd0, 1'b1, 1'b1);
      cycle("up_after", 3'd1, 1'b1, 1'b0);

      // Down scan every 3 cycles from idx 1 with scan_last=3.
      drive(1'b1, MODE_DIRECT, 3'd1);
      cycle("dn_seed", 3'd1, 1'b1, 1'b0);
      scan_div  = 4'd2;
      scan_last = 3'd3;
      drive(1'b1, MODE_SCAN_DOWN, 3'd0);
      cycle("dn_modechg", 3'd1, 1'b1, 1'b0);
      cycle("dn_wait", 3'd1, 1'b1, 1'b0);
      cycle("dn_wait", 3'd1, 1'b1, 1'b0);
      cycle("dn_step0", 3'd0, 1'b1, 1'b0);
      cycle("dn_wait", 3'd0, 1'b1, 1'b0);
      cycle("dn_wait", 3'd0, 1'b1, 1'b0);
      cycle("dn_wrap", 3'd3, 1'b1, 1'b1);
      cycle("dn_wait", 3'd3, 1'b1, 1'b0);
      cycle("dn_wait", 3'd3, 1'b1, 1'b0);
      cycle("dn_step2", 3'd2, 1'b1, 1'b0);
      cycle("dn_wait", 3'd2, 1'b1, 1'b0);
      cycle("dn_wait", 3'd2, 1'b1, 1'b0);
      cycle("dn_step1", 3'd1, 1'b1, 1'b0);
      cycle("dn_wait", 3'd1, 1'b1, 1'b0);
      cycle("dn_wait", 3'd1, 1'b1, 1'b0);
      cycle("dn_step0b", 3'd0, 1'b1, 1'b0);

      // Down scan above scan_last clamps without a wrap.
      drive(1'b1, MODE_DIRECT, 3'd6);
      cycle("clamp_seed", 3'd6, 1'b1, 1'b0);
      scan_div = 4'd0;
      drive(1'b1, MODE_SCAN_DOWN, 3'd0);
      cycle("clamp_modechg", 3'd6, 1'b1, 1'b0);
      cycle("clamp", 3'd3, 1'b1, 1'b0);
      cycle("clamp_next", 3'd2, 1'b1, 1'b0);

      // Hold at idx 4, then resume up scan with scan_div=1.
      drive(1'b1, MODE_DIRECT, 3'd4);
      cycle("hold_seed", 3'd4, 1'b1, 1'b0);
      scan_div  = 4'd1;
      scan_last = 3'd7;
      drive(1'b1, MODE_SCAN_UP, 3'd0);
      cycle("hold_up", 3'd4, 1'b1, 1'b0);
      drive(1'b1, MODE_HOLD, 3'd0);
      for (int i = 0; i < 5; i++) cycle("hold", 3'd4, 1'b1, 1'b0);
      drive(1'b1, MODE_SCAN_UP, 3'd0);
      cycle("resume_chg", 3'd4, 1'b1, 1'b0);
      cycle("resume_wait", 3'd4, 1'b1, 1'b0);
      cycle("resume_step", 3'd5, 1'b1, 1'b0);
      cycle("resume_wait", 3'd5, 1'b1, 1'b0);
      cycle("resume_step", 3'd6, 1'b1, 1'b0);

      // Reset mid scan at idx 6, then restart from 0.
      rst = 1'b1;
      cycle("midrst", 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      cycle("rst_modechg", 3'd0, 1'b1, 1'b0);
      cycle("rst_wait", 3'd0, 1'b1, 1'b0);
      cycle("rst_step", 3'd1, 1'b1, 1'b0);

      // scan_last=0: up scan wraps on every tick.
      scan_div  = 4'd0;
      scan_last = 3'd0;
      cycle("last0_wrap", 3'd0, 1'b1, 1'b1);
      cycle("last0_wrap", 3'd0, 1'b1, 1'b1);
      drive(1'b1, MODE_DIRECT, 3'd2);
      cycle("last0_exit", 3'd2, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
